// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: rotating round-robin grant of up to CDB_PORTS
// execute-unit writeback packets per cycle onto registered broadcast lanes.

package cdb_arbiter_pkg;
    typedef struct packed {
        logic        is_valid;
        logic [5:0]  dest_reg;
        logic [31:0] result;
    } writeback_packet_t;
endpackage

module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int unsigned NUM_SRC   = 4,
    parameter int unsigned CDB_PORTS = 2
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                flush,
    input  writeback_packet_t [NUM_SRC-1:0]     fu_result,
    output logic [NUM_SRC-1:0]                  fu_cdb_gnt,
    output writeback_packet_t [CDB_PORTS-1:0]   cdb,
    output logic                                cdb_busy
);

    localparam int unsigned PTR_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam int unsigned CNT_W = $clog2(NUM_SRC + 1);

    logic [PTR_W-1:0]                  r_rr_ptr;
    writeback_packet_t [CDB_PORTS-1:0] r_cdb;
    logic                              r_busy;

    logic                              w_arb_en;
    logic [NUM_SRC-1:0]                w_gnt;
    logic [PTR_W-1:0]                  w_lane_src [CDB_PORTS];
    logic [CDB_PORTS-1:0]              w_lane_used;
    logic [PTR_W-1:0]                  w_next_ptr;
    logic [CNT_W-1:0]                  w_req_cnt;
    logic [CNT_W-1:0]                  w_gnt_cnt;
    logic                              w_dup;

    // Grants are suppressed during reset and flush; requests are still counted.
    assign w_arb_en = !rst && !flush;

    // Scan sources from rr_ptr with wrap; the k-th requester found takes lane k.
    always_comb begin
        int unsigned v_pos;
        logic [PTR_W-1:0] v_idx;
        w_gnt       = '0;
        w_lane_used = '0;
        w_next_ptr  = r_rr_ptr;
        w_req_cnt   = '0;
        w_gnt_cnt   = '0;
        v_pos       = 0;
        v_idx       = '0;
        for (int unsigned k = 0; k < CDB_PORTS; k++) begin
            w_lane_src[k] = '0;
        end
        for (int unsigned j = 0; j < NUM_SRC; j++) begin
            v_pos = 32'(r_rr_ptr) + j;
            if (v_pos >= NUM_SRC) begin
                v_pos = v_pos - NUM_SRC;
            end
            v_idx = PTR_W'(v_pos);
            if (fu_result[v_idx].is_valid) begin
                w_req_cnt = w_req_cnt + 1'b1;
                if (w_arb_en && (w_gnt_cnt < CNT_W'(CDB_PORTS))) begin
                    w_gnt[v_idx] = 1'b1;
                    for (int unsigned k = 0; k < CDB_PORTS; k++) begin
                        if (w_gnt_cnt == CNT_W'(k)) begin
                            w_lane_src[k]  = v_idx;
                            w_lane_used[k] = 1'b1;
                        end
                    end
                    w_next_ptr = (v_pos == NUM_SRC - 1) ? '0 : PTR_W'(v_pos + 1);
                    w_gnt_cnt  = w_gnt_cnt + 1'b1;
                end
            end
        end
    end

    // Register granted packets onto the lanes and advance the rotation pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cdb    <= '0;
            r_rr_ptr <= '0;
            r_busy   <= 1'b0;
        end else if (flush) begin
            r_cdb <= '0;
        end else begin
            for (int unsigned k = 0; k < CDB_PORTS; k++) begin
                r_cdb[k] <= w_lane_used[k] ? fu_result[w_lane_src[k]] : '0;
            end
            r_rr_ptr <= w_next_ptr;
            r_busy   <= (w_req_cnt > w_gnt_cnt);
        end
    end

    assign fu_cdb_gnt = w_gnt;
    assign cdb        = r_cdb;
    assign cdb_busy   = r_busy;

    // Detect two valid lanes broadcasting the same destination tag.
    always_comb begin
        w_dup = 1'b0;
        for (int unsigned a = 0; a < CDB_PORTS; a++) begin
            for (int unsigned b = a + 1; b < CDB_PORTS; b++) begin
                if (r_cdb[a].is_valid && r_cdb[b].is_valid &&
                    (r_cdb[a].dest_reg == r_cdb[b].dest_reg)) begin
                    w_dup = 1'b1;
                end
            end
        end
    end

    a_gnt_limit: assert property (@(posedge clk) disable iff (rst)
        $countones(fu_cdb_gnt) <= CDB_PORTS);

    a_unique_dest: assert property (@(posedge clk) disable iff (rst) !w_dup);

endmodule

// File: tb/tb_cdb_arbiter.sv
// Scoreboard bench for cdb_arbiter: directed scenarios followed by random
// traffic, checked against a queue-based round-robin reference model.

module tb_cdb_arbiter;
    import cdb_arbiter_pkg::*;

    localparam int NS = 4;
    localparam int NP = 2;

    typedef struct packed {
        writeback_packet_t [NP-1:0] lanes;
        logic                       busy;
    } exp_t;

    logic                         clk = 1'b0;
    logic                         rst = 1'b1;
    logic                         flush = 1'b0;
    writeback_packet_t [NS-1:0]   fu_result = '0;
    logic [NS-1:0]                fu_cdb_gnt;
    writeback_packet_t [NP-1:0]   cdb;
    logic                         cdb_busy;

    int errors = 0;
    int checks = 0;

    exp_t              sb[$];
    writeback_packet_t pkt [NS];
    int                m_ptr  = 0;
    logic              m_busy = 1'b0;

    cdb_arbiter #(.NUM_SRC(NS), .CDB_PORTS(NP)) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .fu_result  (fu_result),
        .fu_cdb_gnt (fu_cdb_gnt),
        .cdb        (cdb),
        .cdb_busy   (cdb_busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1, "timeout");
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic writeback_packet_t new_pkt(input int s);
        writeback_packet_t p;
        p.is_valid = 1'b1;
        p.dest_reg = {4'($urandom), 2'(s)};
        p.result   = $urandom;
        return p;
    endfunction

    // Monitor: each cycle's registered lanes are compared with the oldest prediction.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && sb.size() > 0) begin
            e = sb.pop_front();
            for (int k = 0; k < NP; k++) begin
                check($sformatf("lane%0d", k), 64'(cdb[k]), 64'(e.lanes[k]));
            end
            check("busy", 64'(cdb_busy), 64'(e.busy));
        end
    end

    // One arbitration cycle: drive, predict, check grants, queue lane prediction.
    task automatic step(input logic fl);
        int            req_order[$];
        int            nreq;
        int            ngnt;
        logic [NS-1:0] exp_gnt;
        exp_t          e;
        @(negedge clk);
        #1;
        flush = fl;
        for (int i = 0; i < NS; i++) fu_result[i] = pkt[i];
        #2;
        nreq = 0;
        for (int i = 0; i < NS; i++) if (pkt[i].is_valid) nreq++;
        for (int k = 0; k < NS; k++) begin
            int s;
            s = (m_ptr + k) % NS;
            if (pkt[s].is_valid && !fl) req_order.push_back(s);
        end
        ngnt    = (req_order.size() < NP) ? req_order.size() : NP;
        exp_gnt = '0;
        e.lanes = '0;
        for (int k = 0; k < ngnt; k++) begin
            exp_gnt[req_order[k]] = 1'b1;
            e.lanes[k]            = pkt[req_order[k]];
        end
        if (ngnt > 0) m_ptr = (req_order[ngnt-1] + 1) % NS;
        if (!fl) m_busy = (nreq > ngnt);
        e.busy = m_busy;
        check("gnt", 64'(fu_cdb_gnt), 64'(exp_gnt));
        sb.push_back(e);
        for (int i = 0; i < NS; i++) if (exp_gnt[i]) pkt[i] = '0;
    endtask

    task automatic refill_all();
        for (int s = 0; s < NS; s++) if (!pkt[s].is_valid) pkt[s] = new_pkt(s);
    endtask

    initial begin
        for (int i = 0; i < NS; i++) pkt[i] = '0;

        // Reset state while rst is held, including gating of requests.
        #12;
        for (int i = 0; i < NS; i++) fu_result[i] = new_pkt(i);
        #1;
        check("rst_gnt", 64'(fu_cdb_gnt), 64'(0));
        for (int k = 0; k < NP; k++) check($sformatf("rst_lane%0d", k), 64'(cdb[k]), 64'(0));
        check("rst_busy", 64'(cdb_busy), 64'(0));
        fu_result = '0;
        @(negedge clk);
        #1 rst = 1'b0;

        // Idle after reset.
        for (int c = 0; c < 5; c++) step(1'b0);

        // All four requesting continuously from pointer 0, then drain.
        for (int c = 0; c < 4; c++) begin
            refill_all();
            step(1'b0);
        end
        step(1'b0);

        // Single request on src2.
        pkt[2] = '{is_valid: 1'b1, dest_reg: 6'd7, result: 32'hDEADBEEF};
        step(1'b0);
        step(1'b0);

        // Wrap-around from pointer 3.
        pkt[0] = new_pkt(0);
        pkt[1] = new_pkt(1);
        pkt[3] = new_pkt(3);
        step(1'b0);
        pkt[3] = new_pkt(3);
        step(1'b0);

        // Flush with all requesting, then resume.
        refill_all();
        step(1'b1);
        step(1'b0);
        step(1'b0);
        for (int s = 0; s < NS; s++) pkt[s] = '0;
        step(1'b0);

        // Asynchronous reset between edges while lanes are valid.
        pkt[0] = new_pkt(0);
        pkt[2] = new_pkt(2);
        step(1'b0);
        @(negedge clk);
        #1;
        rst = 1'b1;
        for (int i = 0; i < NS; i++) fu_result[i] = new_pkt(i);
        #1;
        check("arst_gnt", 64'(fu_cdb_gnt), 64'(0));
        for (int k = 0; k < NP; k++) check($sformatf("arst_lane%0d", k), 64'(cdb[k]), 64'(0));
        check("arst_busy", 64'(cdb_busy), 64'(0));
        sb.delete();
        m_ptr  = 0;
        m_busy = 1'b0;
        for (int s = 0; s < NS; s++) pkt[s] = '0;
        fu_result = '0;
        @(negedge clk);
        @(negedge clk);
        #1 rst = 1'b0;
        pkt[1] = new_pkt(1);
        step(1'b0);
        step(1'b0);

        // Random traffic obeying the hold-until-granted contract.
        for (int c = 0; c < 400; c++) begin
            for (int s = 0; s < NS; s++)
                if (!pkt[s].is_valid && ($urandom % 2 == 0)) pkt[s] = new_pkt(s);
            step(($urandom % 16) == 0);
        end
        for (int s = 0; s < NS; s++) pkt[s] = '0;
        step(1'b0);
        step(1'b0);

        @(negedge clk);
        #1;
        check("drain", 64'(sb.size()), 64'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Consumer end of the functional-unit writeback handshake.
- Collects `writeback_packet_t` results from NUM_SRC execute units (ALUs, branch, LSU, MUL), grants up to CDB_PORTS of them per cycle with rotating round-robin priority, and drives the registered common data bus (CDB) to the ROB, reservation stations and PRF.
- Each unit holds its packet until it sees its grant.

Parameters:
- NUM_SRC, 4, number of requesting execute units (≥ 2).
- CDB_PORTS, 2, number of CDB broadcast lanes per cycle (1 ≤ CDB_PORTS ≤ NUM_SRC).

Ports:
- clk  input  1  core clock
- rst  input  1  reset; asynchronous, active-high
- flush  input  1  pipeline flush (mispredict), synchronous
- fu_result  input  NUM_SRC x $bits(writeback_packet_t)  per-unit result packet; request = fu_result[i].is_valid
- fu_cdb_gnt  output  NUM_SRC  per-unit grant, combinational, same cycle as request
- cdb  output  CDB_PORTS x $bits(writeback_packet_t)  registered broadcast lanes
- cdb_busy  output  1  registered; 1 if any request was left ungranted last cycle (perf/debug)

Behaviour:
- **Reset (async, rst=1):**
  - all cdb lanes = '0 (is_valid=0, dest_reg=0, result=0).
  - rr_ptr = 0; cdb_busy = 0.
  - fu_cdb_gnt = 0 while rst is high.
- **Arbitration (combinational):**
  - Scan sources starting at rr_ptr, wrapping modulo NUM_SRC.
  - The first CDB_PORTS sources with is_valid=1 receive fu_cdb_gnt=1.
  - The k-th granted source in scan order is assigned lane k.
  - Lanes with no assignment are idle.
- **Grant rules:**
  - No grant to a source with is_valid=0.
  - At most CDB_PORTS grants per cycle.
  - Grant is never asserted while flush=1 or rst=1.
- **Capture (registered):**
  - On posedge, lane k ← packet of its assigned source.
  - Idle lanes ← '0 (is_valid=0).
  - Latency is exactly 1 cycle from grant to CDB visibility.
  - A CDB lane is valid for exactly one cycle per grant; no duplicates.
- **Source contract:**
  - A source keeps fu_result stable and valid until the cycle it sees fu_cdb_gnt.
  - It may present a new packet in the following cycle.
  - The arbiter never stalls a granted transfer; the CDB has no backpressure.
- **rr_ptr update:**
  - If ≥ 1 grant: rr_ptr ← (index of last granted source + 1) mod NUM_SRC.
  - If no grant: rr_ptr unchanged.
  - Guarantees starvation-free service: any continuously requesting source is granted within ceil(NUM_SRC / CDB_PORTS) cycles.
- **flush:**
  - All lanes ← '0 on the next edge.
  - No grants that cycle; rr_ptr unchanged.
  - Packets already on cdb in the flush cycle remain visible for that cycle only.
- **cdb_busy:** ← 1 if (#requests > #grants) in the previous non-flush cycle, else 0.
- **Simultaneous events:**
  - rst dominates flush.
  - flush dominates requests.
  - All NUM_SRC requesting with NUM_SRC ≤ CDB_PORTS → all granted, no rotation effect beyond the ptr rule.
- **Wrap-around:** the scan from rr_ptr=NUM_SRC-1 continues at 0.
- **Assertion:** per-cycle popcount(fu_cdb_gnt) ≤ CDB_PORTS.
- **Assertion:** no two valid lanes carry the same dest_reg in the same cycle, checked only when sources obey the unique-tag invariant.

Test Plan (NUM_SRC=4, CDB_PORTS=2):
1. **Reset release, no requests:** hold 5 cycles → cdb[*].is_valid=0, fu_cdb_gnt=0000, rr_ptr=0.
2. **Single request:** src2 valid, dest_reg=7, result=0xDEADBEEF → gnt=0100 same cycle; next cycle cdb[0]={valid,7,0xDEADBEEF}, cdb[1] invalid, rr_ptr=3.
3. **All four request continuously from rr_ptr=0:** grants cycle sequence 0011, 1100, 0011, 1100.
   - cdb_busy=1 after each of the first cycles.
   - Each source's packet appears exactly once per two cycles.
4. **Wrap-around, rr_ptr=3:** srcs 0, 1, 3 valid → gnt=1001; lane0=src3, lane1=src0; rr_ptr→1; next cycle (srcs 1, 3 valid) gnt=1010.
5. **Flush:** all valid with flush=1 → gnt=0000; next cycle all lanes invalid; rr_ptr unchanged; following cycle arbitration resumes from the same ptr.
6. **Async reset mid-stream:** assert rst between edges while lanes are valid → cdb lanes drop to invalid immediately, gnt=0; after deassert, src1 alone valid → granted on lane0.
